// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: the state encoding used by both the transmitter
// and the receiver, plus the default bit period for the sensor link.
package uart_defs;

    // Frame states. The 3-bit encoding is shared with the receiver, so the values are pinned.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } uart_state_e;

    // 10 MHz system clock / 115200 baud.
    localparam int DEFAULT_CLOCKS_PER_BIT = 87;

    // Data bits per frame (8N1).
    localparam int FRAME_DATA_BITS = 8;

    // True while a frame is on the line (start, data or stop bit).
    function automatic logic isFrameActive(input uart_state_e state);
        return (state == START_BIT) || (state == DATA_BITS) || (state == STOP_BIT);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles within one bit and flags the last
// cycle of each bit so the transmitter knows when to advance.
module uart_bit_timer
    import uart_defs::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: hold at zero while restarting, wrap on the last cycle of a bit.
    always_comb begin
        count_d = count_q;
        if (restart || bit_end) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_end = (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so the host can
// queue the next byte while a frame is still on the line.
module uart_tx
    import uart_defs::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_data,
    input  logic [7:0] data_to_send,
    output logic       ready,
    output logic       outgoing_bit,
    output logic       is_transmitting,
    output logic       done
);

    localparam logic [2:0] LAST_INDEX = 3'(FRAME_DATA_BITS - 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic        line_q, line_d;

    logic        accept;
    logic        restart_timer;
    logic        bit_end;

    assign accept = send_data && ready;

    uart_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .restart(restart_timer),
        .bit_end(bit_end)
    );

    // State and datapath registers; reset abandons any frame and drops the held byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_index_q <= '0;
            line_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_index_q <= bit_index_d;
            line_q      <= line_d;
        end
    end

    // Next-state and datapath: frame sequencing, line level and holding-register traffic.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_index_d = bit_index_q;
        line_d      = line_q;

        case (state_q)
            IDLE, CLEANUP: begin
                line_d  = 1'b1;
                state_d = IDLE;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    line_d      = 1'b0;
                    state_d     = START_BIT;
                end else if (accept) begin
                    shift_d = data_to_send;
                    line_d  = 1'b0;
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    bit_index_d = '0;
                    line_d      = shift_q[0];
                    state_d     = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_end) begin
                    if (bit_index_q == LAST_INDEX) begin
                        line_d  = 1'b1;
                        state_d = STOP_BIT;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                        line_d      = shift_q[bit_index_q + 3'd1];
                    end
                end
            end
            STOP_BIT: begin
                if (bit_end) begin
                    line_d  = 1'b1;
                    state_d = CLEANUP;
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = IDLE;
            end
        endcase

        // A byte offered mid-frame is parked until the current frame finishes.
        if (accept && isFrameActive(state_q)) begin
            hold_d      = data_to_send;
            hold_full_d = 1'b1;
        end
    end

    // Outputs decoded from registered state only, so none of them can glitch.
    always_comb begin
        ready           = ~hold_full_q;
        outgoing_bit    = line_q;
        is_transmitting = isFrameActive(state_q);
        done            = (state_q == CLEANUP);
        restart_timer   = (state_q == IDLE) || (state_q == CLEANUP);
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: cycle-exact frame checks at 4 clocks/bit,
// a line decoder feeding a byte scoreboard, and a loopback run at 87 clocks/bit.
module tb_uart_tx;

    localparam int CPB          = 4;
    localparam int CPB_LB       = 87;
    localparam int FRAME_CYCLES = 10 * CPB;

    logic       clock = 1'b0;
    logic       reset;

    logic       send4;
    logic [7:0] data4;
    logic       ready4, line4, tx4, done4;

    logic       send87;
    logic [7:0] data87;
    logic       ready87, line87, tx87, done87;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] q4[$];
    logic [7:0] q87[$];
    int done4Count  = 0;
    int done87Count = 0;
    int rx4Count    = 0;
    int rx87Count   = 0;
    bit holdExp;

    always #5 clock = ~clock;

    uart_tx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset          (reset),
        .send_data      (send4),
        .data_to_send   (data4),
        .ready          (ready4),
        .outgoing_bit   (line4),
        .is_transmitting(tx4),
        .done           (done4)
    );

    uart_tx #(.CLOCKS_PER_BIT(CPB_LB)) dutLoop (
        .clock          (clock),
        .reset          (reset),
        .send_data      (send87),
        .data_to_send   (data87),
        .ready          (ready87),
        .outgoing_bit   (line87),
        .is_transmitting(tx87),
        .done           (done87)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d);
        send4 = s;
        data4 = d;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic lineOf(input bit sel);
        return sel ? line87 : line4;
    endfunction

    // Expected line level in cycle c (1-based, counted from the accepting edge).
    function automatic logic expLine(input logic [7:0] b, input int c);
        int bitNo;
        bitNo = (c - 1) / CPB;
        if (bitNo == 0) return 1'b0;
        if (bitNo <= 8) return b[bitNo - 1];
        return 1'b1;
    endfunction

    // Offer a byte during a frame; only expected to be taken if nothing is held.
    task automatic offer(input logic [7:0] b);
        applyStimulus(1'b1, b);
        if (!holdExp) begin
            q4.push_back(b);
            holdExp = 1'b1;
        end
    endtask

    task automatic sendFromIdle(input logic [7:0] b);
        applyStimulus(1'b1, b);
        q4.push_back(b);
        tick();
        applyStimulus(1'b0, 8'h00);
    endtask

    // Walk one frame cycle by cycle, starting in cycle 1.
    task automatic checkFrame(input logic [7:0] b, input int stopAt,
                              input int inj1At, input logic [7:0] inj1,
                              input int inj2At, input logic [7:0] inj2);
        for (int c = 1; c <= FRAME_CYCLES + 1 && c <= stopAt; c++) begin
            checkOutput($sformatf("line_%02h_c%0d", b, c), {31'd0, line4}, {31'd0, expLine(b, c)});
            checkOutput($sformatf("tx_%02h_c%0d", b, c), {31'd0, tx4}, {31'd0, c <= FRAME_CYCLES});
            checkOutput($sformatf("done_%02h_c%0d", b, c), {31'd0, done4}, {31'd0, c == FRAME_CYCLES + 1});
            checkOutput($sformatf("ready_%02h_c%0d", b, c), {31'd0, ready4}, {31'd0, !holdExp});
            if (c == inj1At) offer(inj1);
            if (c == inj2At) offer(inj2);
            tick();
            applyStimulus(1'b0, 8'h00);
            if (c == FRAME_CYCLES + 1 && holdExp) holdExp = 1'b0;
        end
    endtask

    task automatic idleCheck(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_line_%0d", tag, i), {31'd0, line4}, 32'd1);
            checkOutput($sformatf("%s_tx_%0d", tag, i), {31'd0, tx4}, 32'd0);
            checkOutput($sformatf("%s_done_%0d", tag, i), {31'd0, done4}, 32'd0);
            checkOutput($sformatf("%s_ready_%0d", tag, i), {31'd0, ready4}, 32'd1);
            tick();
        end
    endtask

    // Decode one frame mid-bit, starting at the first low sample of the start bit.
    task automatic rxByte(input bit sel, input int cpb, output logic [7:0] b,
                          output logic stopBit, output bit aborted);
        aborted = 1'b0;
        b       = '0;
        stopBit = 1'b0;
        for (int k = 0; k < 9; k++) begin
            int n;
            n = (k == 0) ? cpb + cpb / 2 : cpb;
            for (int w = 0; w < n; w++) begin
                @(negedge clock);
                if (reset) aborted = 1'b1;
            end
            if (aborted) return;
            if (k < 8) b[k] = lineOf(sel);
            else stopBit = lineOf(sel);
        end
    endtask

    always begin : mon4
        logic [7:0] b;
        logic       stopBit;
        bit         ab;
        @(negedge clock);
        if (reset === 1'b0 && line4 === 1'b0) begin
            rxByte(1'b0, CPB, b, stopBit, ab);
            if (!ab) begin
                rx4Count++;
                checkOutput("rx4_stop", {31'd0, stopBit}, 32'd1);
                checkOutput("rx4_pending", {31'd0, q4.size() > 0}, 32'd1);
                if (q4.size() > 0) checkOutput("rx4_byte", {24'd0, b}, {24'd0, q4.pop_front()});
            end
        end
    end

    always begin : mon87
        logic [7:0] b;
        logic       stopBit;
        bit         ab;
        @(negedge clock);
        if (reset === 1'b0 && line87 === 1'b0) begin
            rxByte(1'b1, CPB_LB, b, stopBit, ab);
            if (!ab) begin
                rx87Count++;
                checkOutput("rx87_stop", {31'd0, stopBit}, 32'd1);
                checkOutput("rx87_pending", {31'd0, q87.size() > 0}, 32'd1);
                if (q87.size() > 0) checkOutput("rx87_byte", {24'd0, b}, {24'd0, q87.pop_front()});
            end
        end
    end

    always @(negedge clock) begin
        if (done4 === 1'b1) done4Count++;
        if (done87 === 1'b1) done87Count++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] lbBytes[4];
        int guard;
        lbBytes[0] = 8'h00;
        lbBytes[1] = 8'hFF;
        lbBytes[2] = 8'hA5;
        lbBytes[3] = 8'h5A;

        reset   = 1'b1;
        send87  = 1'b0;
        data87  = 8'h00;
        holdExp = 1'b0;
        applyStimulus(1'b0, 8'h00);
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_line", {31'd0, line4}, 32'd1);
        checkOutput("rst_tx", {31'd0, tx4}, 32'd0);
        checkOutput("rst_done", {31'd0, done4}, 32'd0);
        checkOutput("rst_ready", {31'd0, ready4}, 32'd1);
        reset = 1'b0;
        tick();
        idleCheck("idle0", 2);

        $display("[TB] single byte 0xA5");
        sendFromIdle(8'hA5);
        checkFrame(8'hA5, 1000, 0, 8'h00, 0, 8'h00);
        idleCheck("idle1", 3);

        $display("[TB] back-to-back 0x00 then 0xFF");
        sendFromIdle(8'h00);
        checkFrame(8'h00, 1000, 5, 8'hFF, 0, 8'h00);
        checkFrame(8'hFF, 1000, 0, 8'h00, 0, 8'h00);
        idleCheck("idle2", 3);

        $display("[TB] overflow 0x3C, 0x81 held, 0x7E offered");
        sendFromIdle(8'h3C);
        checkFrame(8'h3C, 1000, 3, 8'h81, 10, 8'h7E);
        checkFrame(8'h81, 1000, 0, 8'h00, 0, 8'h00);
        idleCheck("idle3", 3);

        $display("[TB] reset in cycle 17 of 0x55 with 0xC3 held");
        sendFromIdle(8'h55);
        checkFrame(8'h55, 16, 5, 8'hC3, 0, 8'h00);
        reset = 1'b1;
        q4.delete();
        holdExp = 1'b0;
        tick();
        reset = 1'b0;
        idleCheck("postrst", 45);

        checkOutput("rx4_count", rx4Count, 32'd5);
        checkOutput("done4_count", done4Count, 32'd5);
        checkOutput("q4_left", q4.size(), 32'd0);

        $display("[TB] loopback at 87 clocks per bit");
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (ready87 !== 1'b1 && guard < 3000) begin
                tick();
                guard++;
            end
            checkOutput($sformatf("lb_ready_wait_%0d", i), {31'd0, guard < 3000}, 32'd1);
            send87 = 1'b1;
            data87 = lbBytes[i];
            q87.push_back(lbBytes[i]);
            tick();
            send87 = 1'b0;
        end
        guard = 0;
        while ((done87Count < 4 || rx87Count < 4) && guard < 10000) begin
            tick();
            guard++;
        end
        checkOutput("lb_finish_wait", {31'd0, guard < 10000}, 32'd1);
        repeat (3 * CPB_LB) tick();
        checkOutput("rx87_count", rx87Count, 32'd4);
        checkOutput("done87_count", done87Count, 32'd4);
        checkOutput("q87_left", q87.size(), 32'd0);
        checkOutput("lb_line_idle", {31'd0, line87}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
